frame_receiver_p: RTL and testbench
===================================

FRAME_RECEIVER_P -- requirements
Module: frame_receiver_p

Interface
REQ-001 SHALL have parameter PRE_LEN, default 12: number of consecutive accepted 1-bits that constitute a preamble (2..32).
REQ-002 SHALL have parameter LEN_W, default 12: width of the SIGNAL length field in bits (4..16).
REQ-003 SHALL have parameter SIG_BITS, default 24: number of SIGNAL bits following the preamble; SIG_BITS >= LEN_W+6.
REQ-004 SHALL have parameter HDR_BYTES, default 5: fixed byte overhead added to length when computing the frame end.
REQ-005 SHALL have parameter SEED, default 7'h7F: descrambler LFSR load value at data start.
REQ-006 Clk  in  1  single clock; all state changes on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 x  in  1  serial received bit.
REQ-009 x_valid  in  1  qualifies x; when 0, no state, counter or LFSR advances.
REQ-010 num_pads  in  3  pad byte count, sampled at the last SIGNAL bit.
REQ-011 y  out  1  output bit: SIGNAL bits passed through, data bits descrambled.
REQ-012 y_valid  out  1  y carries a post-preamble bit.
REQ-013 sof  out  1  one-cycle pulse with the first SIGNAL bit on y.
REQ-014 eof  out  1  one-cycle pulse with the last frame bit on y.
REQ-015 length  out  LEN_W  captured length field, held until the next sof.
REQ-016 rate  out  4  captured SIGNAL bits 0..3, MSB first, held until the next sof.
REQ-017 parity_err  out  1  one-cycle pulse on SIGNAL parity failure.
REQ-018 busy  out  1  high in SIGNAL or DATA state.

Function
REQ-019 SHALL implement states HUNT, SIGNAL and DATA; the bit count bcnt is reset to 0 on entry to SIGNAL.
REQ-020 In HUNT, SHALL shift each accepted bit into a PRE_LEN shift register; when the register becomes all ones, SHALL enter SIGNAL on that edge.
REQ-021 In SIGNAL, SHALL shift SIGNAL bits 5..5+LEN_W-1 into length MSB first and bits 0..3 into rate.
REQ-022 SHALL treat SIGNAL bit 5+LEN_W as the even-parity bit over bits 0..4+LEN_W.
REQ-023 After SIGNAL bit SIG_BITS-1, SHALL load the LFSR with SEED and enter DATA.
REQ-024 Descrambler SHALL use polynomial x^7+x^4+1: fb = s[6]^s[3]; y = x^fb; s <= {s[5:0],fb} per accepted data bit.
REQ-025 Every accepted post-preamble bit SHALL appear on y with y_valid=1 exactly one cycle later; otherwise y=0 and y_valid=0.
REQ-026 The frame SHALL end after END = 8*(length+HDR_BYTES+num_pads) post-preamble bits, computed LEN_W+4 bits wide without overflow.
REQ-027 If END <= SIG_BITS, SHALL end the frame after the last SIGNAL bit; no DATA bits are produced.
REQ-028 On the end bit, SHALL pulse eof with that bit, return to HUNT, and clear the preamble register so a fresh PRE_LEN ones are required.
REQ-029 Preamble-like patterns inside SIGNAL or DATA SHALL be ignored.
REQ-030 x_valid=0 cycles inside a frame SHALL stall all counters and the LFSR without ending the frame.

Reset
REQ-031 Reset SHALL force HUNT and clear the preamble register, bcnt, LFSR (to SEED), length, rate, y, y_valid, sof, eof, parity_err and busy to 0.
REQ-032 Reset asserted mid-frame SHALL abort without eof; the first output after release requires a new preamble.

Configuration
REQ-033 With RX_PARITY_CHECK_EN defined, a parity failure SHALL pulse parity_err one cycle after the parity bit, abort to HUNT without eof, and clear the preamble register.
REQ-034 Without RX_PARITY_CHECK_EN, parity SHALL be ignored and parity_err SHALL be tied to 0.

Verification
REQ-035 Defaults; 12 ones, SIGNAL with length=2, num_pads=0, good parity -> sof; 24 pass-through bits; eof on post-preamble bit 56; y matches reference descrambler with seed 7F.
REQ-036 11 ones, a 0, then 12 ones -> no sof until the 24th input bit's successor cycle; busy stays 0 before that.
REQ-037 Same frame with x_valid toggling 1/0 each cycle -> identical y sequence; y_valid only on the valid cycles; eof after 56 valid bits.
REQ-038 RX_PARITY_CHECK_EN defined with a flipped parity bit -> parity_err pulse, busy falls, no eof; the next good frame is received normally.
REQ-039 length=0, HDR_BYTES=2, num_pads=0 (END=16 <= 24) -> eof with SIGNAL bit 23 and no DATA bits.
REQ-040 Reset pulsed at DATA bit 10 -> all outputs 0 next cycle, no eof; 12 new ones are needed for the next sof.

Source files
------------

// File: rtl/frame_receiver_p.sv
// frame_receiver_p: preamble hunter, SIGNAL field capture and x^7+x^4+1 data descrambler.
// Define RX_PARITY_CHECK_EN to abort frames whose SIGNAL parity fails.
module frame_receiver_p #(
  parameter int PRE_LEN = 12,
  parameter int LEN_W = 12,
  parameter int SIG_BITS = 24,
  parameter int HDR_BYTES = 5,
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  input  logic x_valid,
  input  logic [2:0] num_pads,
  output logic y,
  output logic y_valid,
  output logic sof,
  output logic eof,
  output logic [LEN_W-1:0] length,
  output logic [3:0] rate,
  output logic parity_err,
  output logic busy
);
  localparam int CW = LEN_W + 4;
  typedef enum logic [1:0] {HUNT, SIGNAL, DATA} state_t;
  state_t state, state_n;
  logic [PRE_LEN-1:0] pre, pre_n;
  logic [CW-1:0] bcnt, end_m1, frame_end;
  logic [6:0] s;
  logic fb, sig_last, short_frame, par_bad, eof_n;
  assign pre_n = {pre[PRE_LEN-2:0], x};
  assign fb = s[6] ^ s[3];
  assign sig_last = bcnt == CW'(SIG_BITS - 1);
  assign frame_end = (CW'(length) + CW'(HDR_BYTES) + CW'(num_pads)) << 3;
  assign short_frame = frame_end <= CW'(SIG_BITS);
  assign busy = state != HUNT;
`ifdef RX_PARITY_CHECK_EN
  logic par;
  always_ff @(posedge clk)
    if (reset || state != SIGNAL) par <= 1'b0;
    else if (x_valid) par <= par ^ x;
  assign par_bad = state == SIGNAL && bcnt == CW'(5 + LEN_W) && (par ^ x);
`else
  assign par_bad = 1'b0;
`endif
  always_comb begin
    state_n = state;
    eof_n = 1'b0;
    if (x_valid) begin
      if (state == HUNT) state_n = &pre_n ? SIGNAL : HUNT;
      else if (state == SIGNAL) state_n = (par_bad || (sig_last && short_frame)) ? HUNT : sig_last ? DATA : SIGNAL;
      else state_n = bcnt == end_m1 ? HUNT : DATA;
      eof_n = (state == SIGNAL && sig_last && short_frame && !par_bad) || (state == DATA && bcnt == end_m1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
      pre <= '0;
      bcnt <= '0;
      end_m1 <= '0;
      s <= SEED;
      length <= '0;
      rate <= '0;
      y <= 1'b0;
      y_valid <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state <= state_n;
      y_valid <= x_valid && state != HUNT;
      y <= x_valid && state != HUNT && (state == DATA ? x ^ fb : x);
      sof <= x_valid && state == SIGNAL && bcnt == '0;
      eof <= eof_n;
      parity_err <= x_valid && par_bad;
      if (x_valid) begin
        if (state == HUNT) begin
          // cleared on lock so the register is already empty when the frame ends
          pre <= &pre_n ? '0 : pre_n;
          bcnt <= '0;
        end else begin
          bcnt <= bcnt + CW'(1);
          if (state == SIGNAL) begin
            if (bcnt < CW'(4)) rate <= {rate[2:0], x};
            if (bcnt >= CW'(5) && bcnt < CW'(5 + LEN_W)) length <= {length[LEN_W-2:0], x};
            if (sig_last) begin
              s <= SEED;
              end_m1 <= frame_end - CW'(1);
            end
          end else s <= {s[5:0], fb};
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_receiver_p.sv
// tb_frame_receiver_p: scoreboard bench for frame_receiver_p (HDR_BYTES 5 and 2 instances).
module tb_frame_receiver_p;
  localparam int LW = 12;
`ifdef RX_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, x = 1'b0, x_valid = 1'b0, sel = 1'b0;
  logic [2:0] num_pads = '0;
  logic y1, yv1, sof1, eof1, pe1, busy1, y2, yv2, sof2, eof2, pe2, busy2;
  logic [LW-1:0] len1, len2;
  logic [3:0] rate1, rate2;
  logic y, yv, sof, eof, pe, busy;
  logic [LW-1:0] len_o;
  logic [3:0] rate_o;
  frame_receiver_p u1 (.clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .num_pads(num_pads),
    .y(y1), .y_valid(yv1), .sof(sof1), .eof(eof1), .length(len1), .rate(rate1), .parity_err(pe1), .busy(busy1));
  frame_receiver_p #(.HDR_BYTES(2)) u2 (.clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .num_pads(num_pads),
    .y(y2), .y_valid(yv2), .sof(sof2), .eof(eof2), .length(len2), .rate(rate2), .parity_err(pe2), .busy(busy2));
  assign {y, yv, sof, eof, pe, busy, len_o, rate_o} = sel ? {y2, yv2, sof2, eof2, pe2, busy2, len2, rate2}
                                                          : {y1, yv1, sof1, eof1, pe1, busy1, len1, rate1};
  always #5 clk = ~clk;
  typedef struct packed {logic y, sof, eof;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit fr = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic b, input logic v, input logic post, input exp_t e);
    x = b;
    x_valid = v;
    if (v && post) q.push_back(e);
    @(posedge clk);
    #1;
    chk("y_valid", yv, v && post);
    chk("busy", busy, fr);
    if (yv) begin
      if (q.size() == 0) chk("orphan", q.size(), 1);
      else begin
        exp_t t;
        t = q.pop_front();
        chk("y", y, t.y);
        chk("sof", sof, t.sof);
        chk("eof", eof, t.eof);
      end
    end else chk("idle", {y, sof, eof}, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom % 2), 1'b0, 1'b0, '0);
  endtask
  task automatic bits(input logic [31:0] v, input int n);
    fr = 1'b0;
    for (int i = 0; i < n; i++) drive(v[i], 1'b1, 1'b0, '0);
  endtask
  task automatic send_frame(input logic [3:0] rt, input int len, input int pads, input bit tog,
                            input bit flip, input bit ones, input int rst_at);
    logic [23:0] sig;
    logic [6:0] s;
    logic p, b, abort;
    int n, endb;
    exp_t e;
    endb = 8 * (len + (sel ? 2 : 5) + pads);
    n = endb <= 24 ? 24 : endb;
    sig = '0;
    for (int i = 0; i < 4; i++) sig[i] = rt[3-i];
    for (int i = 0; i < LW; i++) sig[5+i] = len[LW-1-i];
    p = 1'b0;
    for (int i = 0; i < 5 + LW; i++) p ^= sig[i];
    sig[5+LW] = p ^ flip;
    num_pads = pads[2:0];
    for (int i = 0; i < 12; i++) begin
      if (tog) idle(1);
      fr = i == 11;
      drive(1'b1, 1'b1, 1'b0, '0);
    end
    s = 7'h7F;
    for (int i = 0; i < n; i++) begin
      if (tog) idle(1);
      if (i == rst_at) begin
        reset = 1'b1;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out", {y, yv, sof, eof, pe, busy, len_o, rate_o}, 0);
        reset = 1'b0;
        q.delete();
        fr = 1'b0;
        return;
      end
      b = i < 24 ? sig[i] : (ones ? 1'b1 : 1'($urandom % 2));
      e.y = b;
      if (i >= 24) begin
        e.y = b ^ s[6] ^ s[3];
        s = {s[5:0], s[6] ^ s[3]};
      end
      abort = flip && PEN && i == 5 + LW;
      e.sof = i == 0;
      e.eof = i == n - 1;
      fr = !(i == n - 1 || abort);
      drive(b, 1'b1, 1'b1, e);
      if (i == 5 + LW) chk("parity_err", pe, abort);
      if (abort) return;
    end
    chk("length", len_o, len);
    chk("rate", rate_o, rt);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {y, yv, sof, eof, pe, busy, len_o, rate_o}, 0);
    reset = 1'b0;
    send_frame(4'hB, 2, 0, 0, 0, 0, -1);
    bits(32'h7FF, 12);
    send_frame(4'h5, 3, 2, 0, 0, 0, -1);
    send_frame(4'hD, 2, 0, 1, 0, 0, -1);
    bits(0, 3);
    send_frame(4'h3, 1, 0, 0, 1, 0, -1);
    send_frame(4'h9, 4, 7, 0, 0, 1, -1);
    send_frame(4'hA, 2, 0, 0, 0, 0, 34);
    bits(32'h7FF, 12);
    send_frame(4'h6, 2, 1, 0, 0, 0, -1);
    sel = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(4'hC, 0, 0, 0, 0, 0, -1);
    send_frame(4'h7, 1, 0, 0, 0, 0, -1);
    send_frame(4'h1, 1, 1, 1, 0, 0, -1);
    idle(2);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
